vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, idle cycles in COLLECT before auto-refund.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port coin_valid  input  1  one-cycle strobe: coin_value is valid this cycle.
REQ-005 SHALL have port coin_value  input  4  coin worth in credit units.
REQ-006 SHALL have port coffee_price  input  4  selected product price; sampled only per REQ-011.
REQ-007 SHALL have port cancel  input  1  customer abort request, level-sampled.
REQ-008 SHALL have port dispense_done  input  1  mechanism acknowledge that the cup is delivered.
REQ-009 SHALL have outputs LED_yellow (1, partial credit held), LED_green (1, dispensing), dispense (1, held until acknowledged), refund (1, one-cycle strobe), refund_value (4, amount returned, valid with refund), coin_reject (1, one-cycle strobe), credit (4, current credit).

Function
REQ-010 SHALL implement states IDLE, COLLECT, DISPENSE, CHANGE, REFUND as a Moore FSM for all LED and dispense outputs.
REQ-011 IDLE: on coin_valid with coffee_price != 0, SHALL latch coffee_price into price_q, load credit = coin_value, and enter COLLECT next cycle; if coffee_price == 0 or coin_value == 0, SHALL pulse coin_reject next cycle and stay in IDLE.
REQ-012 COLLECT: on coin_valid, if credit + coin_value > 15, SHALL pulse coin_reject and leave credit unchanged; otherwise SHALL register credit + coin_value (4-bit, no wrap permitted).
REQ-013 COLLECT: when registered credit >= price_q, SHALL enter DISPENSE on the next edge; the compare uses registered credit, giving a 1-cycle decision latency after the last coin.
REQ-014 COLLECT: cancel SHALL enter REFUND; coin_valid coincident with cancel SHALL be rejected (coin_reject pulse, credit unchanged).
REQ-015 COLLECT: the timeout counter SHALL clear on entry and on every accepted coin, increment otherwise, and on reaching TIMEOUT_CYCLES-1 SHALL enter REFUND.
REQ-016 DISPENSE: dispense and LED_green SHALL be 1; the FSM SHALL hold until dispense_done == 1; cancel and coin_valid SHALL be ignored (coins rejected).
REQ-017 On dispense_done in DISPENSE, SHALL go to CHANGE if credit > price_q (under CHANGE_RETURN_EN), else to IDLE with credit cleared.
REQ-018 CHANGE: SHALL pulse refund for one cycle with refund_value = credit - price_q, clear credit, and return to IDLE.
REQ-019 REFUND: SHALL pulse refund for one cycle with refund_value = credit, clear credit, and return to IDLE.
REQ-020 LED_yellow SHALL be 1 exactly in COLLECT; refund_value SHALL be 0 whenever refund == 0.
REQ-021 coin_valid arriving in CHANGE or REFUND SHALL be rejected with coin_reject.

Reset
REQ-022 While rst == 1, SHALL force state IDLE, credit 0, price_q 0, timeout counter 0, and all outputs 0, regardless of the clock.
REQ-023 Reset mid-DISPENSE or mid-COLLECT SHALL discard credit without a refund pulse.

Configuration
REQ-024 Macro CHANGE_RETURN_EN defined: SHALL provide the CHANGE state per REQ-017/REQ-018.
REQ-025 Macro CHANGE_RETURN_EN undefined: CHANGE SHALL not be synthesised; excess credit SHALL be forfeited and DISPENSE SHALL return directly to IDLE.

Structure
REQ-026 Package vend_pkg SHALL hold the state enum type, CREDIT_W = 4, and CREDIT_MAX = 15.
REQ-027 A sub-module credit_acc SHALL hold the credit register, overflow check, and clear/load control; the FSM and timeout counter reside in vend_controller.

Verification
REQ-028 Reset, price 5, coins 2,3 -> credit 5, DISPENSE one cycle after the second coin, dispense held until dispense_done, then IDLE with no refund.
REQ-029 Price 4, coins 3,3 with CHANGE_RETURN_EN -> after dispense_done, refund = 1 for one cycle, refund_value = 2; without the macro, no refund is issued.
REQ-030 Price 12, coins 10,10 -> second coin triggers coin_reject, credit stays 10; cancel -> refund_value = 10.
REQ-031 TIMEOUT_CYCLES = 8, price 6, one coin 2, no further input -> refund_value = 2 exactly 8 cycles after the coin is accepted.
REQ-032 Price 9, coin 4, then cancel and coin 3 in the same cycle -> coin_reject, refund_value = 4; rst asserted mid-DISPENSE -> all outputs 0 immediately, no refund.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Optional feature macro used by the controller: CHANGE_RETURN_EN.
package vend_pkg;

    localparam int CREDIT_W = 4;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 4'd15;

    typedef logic [CREDIT_W-1:0] credit_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } vend_state_e;

    // True when a + b still fits in the credit register without wrapping.
    function automatic logic credit_fits(input credit_t a, input credit_t b);
        return ({1'b0, a} + {1'b0, b}) <= {1'b0, CREDIT_MAX};
    endfunction

endpackage

// File: rtl/credit_acc.sv
// Credit register with clear/load/add control and an overflow check on the
// candidate coin, so the controller can accept or reject it in the same cycle.
module credit_acc
    import vend_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                add,
    input  logic [CREDIT_W-1:0] add_val,
    output logic                add_fits,
    output logic [CREDIT_W-1:0] credit
);

    // Independent of add so the controller can use it to decide add.
    assign add_fits = credit_fits(credit, add_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= '0;
        end else if (clr) begin
            credit <= '0;
        end else if (load) begin
            credit <= load_val;
        end else if (add && add_fits) begin
            credit <= credit + add_val;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Coffee vending controller: coin collection, dispense handshake, refunds.
// Define CHANGE_RETURN_EN to return excess credit as change after dispensing.
module vend_controller
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic [CREDIT_W-1:0] coffee_price,
    input  logic                cancel,
    input  logic                dispense_done,
    output logic                LED_yellow,
    output logic                LED_green,
    output logic                dispense,
    output logic                refund,
    output logic [CREDIT_W-1:0] refund_value,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    vend_state_e         state, state_nxt;
    logic [CREDIT_W-1:0] price_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                tmo_inc;
    logic                reject_nxt;
    logic                acc_clr, acc_load, acc_add, acc_fits;

    credit_acc u_credit_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .load     (acc_load),
        .load_val (coin_value),
        .add      (acc_add),
        .add_val  (coin_value),
        .add_fits (acc_fits),
        .credit   (credit)
    );

    always_comb begin
        state_nxt  = state;
        acc_clr    = 1'b0;
        acc_load   = 1'b0;
        acc_add    = 1'b0;
        tmo_inc    = 1'b0;
        reject_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (coin_valid) begin
                    if (coffee_price != '0 && coin_value != '0) begin
                        acc_load  = 1'b1;
                        state_nxt = ST_COLLECT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                // Cancel wins over a ready dispense; any coin this cycle bounces.
                if (cancel) begin
                    reject_nxt = coin_valid;
                    state_nxt  = ST_REFUND;
                end else if (credit >= price_q) begin
                    reject_nxt = coin_valid;
                    state_nxt  = ST_DISPENSE;
                end else begin
                    acc_add    = coin_valid && acc_fits;
                    reject_nxt = coin_valid && !acc_fits;
                    if (acc_add) begin
                        tmo_inc = 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_nxt = ST_REFUND;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                reject_nxt = coin_valid;
                if (dispense_done) begin
`ifdef CHANGE_RETURN_EN
                    if (credit > price_q) begin
                        state_nxt = ST_CHANGE;
                    end else begin
                        acc_clr   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
`else
                    // Excess credit is forfeited in this build.
                    acc_clr   = 1'b1;
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef CHANGE_RETURN_EN
            ST_CHANGE: begin
                reject_nxt = coin_valid;
                acc_clr    = 1'b1;
                state_nxt  = ST_IDLE;
            end
`endif
            ST_REFUND: begin
                reject_nxt = coin_valid;
                acc_clr    = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                acc_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            price_q     <= '0;
            tmo_cnt     <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            coin_reject <= reject_nxt;
            if (acc_load) begin
                price_q <= coffee_price;
            end
            // Anything other than an idle COLLECT cycle restarts the count.
            tmo_cnt <= tmo_inc ? tmo_cnt + TMO_W'(1) : '0;
        end
    end

    // Moore outputs; refund lasts exactly the one cycle spent in CHANGE/REFUND.
    always_comb begin
        LED_yellow   = (state == ST_COLLECT);
        LED_green    = (state == ST_DISPENSE);
        dispense     = (state == ST_DISPENSE);
        refund       = 1'b0;
        refund_value = '0;
        if (state == ST_REFUND) begin
            refund       = 1'b1;
            refund_value = credit;
        end
`ifdef CHANGE_RETURN_EN
        if (state == ST_CHANGE) begin
            refund       = 1'b1;
            refund_value = credit - price_q;
        end
`endif
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: a vector table plus hand-written multi-cycle
// sequences (timeout, async reset mid-dispense); expectations go through a queue.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic [3:0] coffee_price;
    logic       cancel;
    logic       dispense_done;
    logic       LED_yellow, LED_green, dispense, refund, coin_reject;
    logic [3:0] refund_value, credit;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        rst;
        logic        cv;
        logic [3:0]  cval;
        logic [3:0]  price;
        logic        cancel;
        logic        done;
        logic [12:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [12:0] sb[$];

    vend_controller #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .coffee_price  (coffee_price),
        .cancel        (cancel),
        .dispense_done (dispense_done),
        .LED_yellow    (LED_yellow),
        .LED_green     (LED_green),
        .dispense      (dispense),
        .refund        (refund),
        .refund_value  (refund_value),
        .coin_reject   (coin_reject),
        .credit        (credit)
    );

    always #5 clk = ~clk;

    // Expected outputs: {yellow, green, dispense, refund, refund_value, coin_reject, credit}
    function automatic logic [12:0] o(input logic y, input logic g, input logic d,
                                      input logic r, input logic [3:0] rv,
                                      input logic cr, input logic [3:0] cred);
        return {y, g, d, r, rv, cr, cred};
    endfunction

    function automatic vec_t v(input logic r, input logic cv, input logic [3:0] cval,
                               input logic [3:0] pr, input logic ca, input logic dn,
                               input logic [12:0] e);
        vec_t t;
        t.rst = r; t.cv = cv; t.cval = cval; t.price = pr;
        t.cancel = ca; t.done = dn; t.exp = e;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] act;
        act = {LED_yellow, LED_green, dispense, refund, refund_value, coin_reject, credit};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got y%b g%b d%b r%b rv%0d cr%b cred%0d, expected y%b g%b d%b r%b rv%0d cr%b cred%0d",
                      tag, act[12], act[11], act[10], act[9], act[8:5], act[4], act[3:0],
                      exp[12], exp[11], exp[10], exp[9], exp[8:5], exp[4], exp[3:0]);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, compare after the edge.
    task automatic step(input logic r, input logic cv, input logic [3:0] cval,
                        input logic [3:0] pr, input logic ca, input logic dn,
                        input logic [12:0] exp, input string tag);
        rst = r; coin_valid = cv; coin_value = cval; coffee_price = pr;
        cancel = ca; dispense_done = dn;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        chk(tag, sb.pop_front());
    endtask

    initial begin
        logic [12:0] z;
        z = '0;

        // Reset, price 5, coins 2,3 -> dispense one cycle later, no refund.
        tbl.push_back(v(1, 0, 0, 0, 0, 0, z));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, z));
        tbl.push_back(v(0, 1, 2, 5, 0, 0, o(1, 0, 0, 0, 0, 0, 2)));
        tbl.push_back(v(0, 1, 3, 5, 0, 0, o(1, 0, 0, 0, 0, 0, 5)));
        tbl.push_back(v(0, 0, 0, 5, 0, 0, o(0, 1, 1, 0, 0, 0, 5)));
        tbl.push_back(v(0, 0, 0, 5, 0, 0, o(0, 1, 1, 0, 0, 0, 5)));
        tbl.push_back(v(0, 0, 0, 5, 0, 1, z));
        tbl.push_back(v(0, 0, 0, 5, 0, 0, z));
        // Price 4, coins 3,3: change of 2 only when change return is built in.
        tbl.push_back(v(0, 1, 3, 4, 0, 0, o(1, 0, 0, 0, 0, 0, 3)));
        tbl.push_back(v(0, 1, 3, 4, 0, 0, o(1, 0, 0, 0, 0, 0, 6)));
        tbl.push_back(v(0, 0, 0, 4, 0, 0, o(0, 1, 1, 0, 0, 0, 6)));
`ifdef CHANGE_RETURN_EN
        tbl.push_back(v(0, 0, 0, 4, 0, 1, o(0, 0, 0, 1, 2, 0, 6)));
`else
        tbl.push_back(v(0, 0, 0, 4, 0, 1, z));
`endif
        tbl.push_back(v(0, 0, 0, 4, 0, 0, z));
        // Price 12, coins 10,10: overflow reject, then cancel refunds 10; coin in REFUND bounces.
        tbl.push_back(v(0, 1, 10, 12, 0, 0, o(1, 0, 0, 0, 0, 0, 10)));
        tbl.push_back(v(0, 1, 10, 12, 0, 0, o(1, 0, 0, 0, 0, 1, 10)));
        tbl.push_back(v(0, 0, 0, 12, 1, 0, o(0, 0, 0, 1, 10, 0, 10)));
        tbl.push_back(v(0, 1, 5, 12, 0, 0, o(0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(v(0, 0, 0, 12, 0, 0, z));
        // IDLE rejects: zero price, zero coin.
        tbl.push_back(v(0, 1, 3, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(v(0, 1, 0, 5, 0, 0, o(0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(v(0, 0, 0, 5, 0, 0, z));
        // Price 9, coin 4, then cancel with coin 3 -> reject and refund 4.
        tbl.push_back(v(0, 1, 4, 9, 0, 0, o(1, 0, 0, 0, 0, 0, 4)));
        tbl.push_back(v(0, 1, 3, 9, 1, 0, o(0, 0, 0, 1, 4, 1, 4)));
        tbl.push_back(v(0, 0, 0, 9, 0, 0, z));
        // DISPENSE ignores cancel and rejects coins.
        tbl.push_back(v(0, 1, 3, 3, 0, 0, o(1, 0, 0, 0, 0, 0, 3)));
        tbl.push_back(v(0, 0, 0, 3, 0, 0, o(0, 1, 1, 0, 0, 0, 3)));
        tbl.push_back(v(0, 1, 2, 3, 1, 0, o(0, 1, 1, 0, 0, 1, 3)));
        tbl.push_back(v(0, 0, 0, 3, 0, 1, z));
        // Credit exactly 15 is accepted.
        tbl.push_back(v(0, 1, 8, 15, 0, 0, o(1, 0, 0, 0, 0, 0, 8)));
        tbl.push_back(v(0, 1, 7, 15, 0, 0, o(1, 0, 0, 0, 0, 0, 15)));
        tbl.push_back(v(0, 0, 0, 15, 0, 0, o(0, 1, 1, 0, 0, 0, 15)));
        tbl.push_back(v(0, 0, 0, 15, 0, 1, z));

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].cv, tbl[i].cval, tbl[i].price, tbl[i].cancel,
                 tbl[i].done, tbl[i].exp, $sformatf("vec%0d", i));

        // Timeout of 8: coin 2 accepted, refund exactly 8 cycles later.
        step(0, 1, 2, 6, 0, 0, o(1, 0, 0, 0, 0, 0, 2), "tmo_accept");
        for (int k = 1; k <= 7; k++)
            step(0, 0, 0, 6, 0, 0, o(1, 0, 0, 0, 0, 0, 2), $sformatf("tmo_wait%0d", k));
        step(0, 0, 0, 6, 0, 0, o(0, 0, 0, 1, 2, 0, 2), "tmo_refund");
        step(0, 0, 0, 6, 0, 0, z, "tmo_idle");

        // Async reset mid-DISPENSE: outputs drop at once, no refund afterwards.
        step(0, 1, 2, 2, 0, 0, o(1, 0, 0, 0, 0, 0, 2), "rst_collect");
        step(0, 0, 0, 2, 0, 0, o(0, 1, 1, 0, 0, 0, 2), "rst_dispense");
        rst = 1'b1;
        #1;
        chk("rst_async", z);
        step(1, 0, 0, 2, 0, 0, z, "rst_held");
        step(0, 0, 0, 2, 0, 0, z, "rst_release");
        step(0, 0, 0, 2, 0, 1, z, "rst_no_refund");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
